mesh_router_rr: RTL

Parametrised 5-port mesh router: PE, N, S, E, W. Each input port has a FIFO with valid/ready flow control. Flits are routed X-first, then Y, using the hop counters in the header, and each forwarded flit has one hop decremented. Each output port has a round-robin arbiter and a registered output stage. The block replaces the fixed-width, bufferless router tile in the NoC mesh. Instances connect neighbour-to-neighbour, with the PE port going to the local processing element.

---
 rtl/mesh_router_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mesh_router_rr.sv
// Five-port mesh router (PE, N, S, E, W) with per-input FIFOs, X-then-Y hop routing,
// per-output round-robin arbitration and registered output stages.
module mesh_router_rr #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4:0]                in_valid,
    input  logic [5*DATA_WIDTH-1:0]   in_data,
    output logic [4:0]                in_ready,
    output logic [4:0]                out_valid,
    output logic [5*DATA_WIDTH-1:0]   out_data,
    input  logic [4:0]                out_ready
);
    localparam int W  = DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] P_PE = 3'd0;
    localparam logic [2:0] P_N  = 3'd1;
    localparam logic [2:0] P_S  = 3'd2;
    localparam logic [2:0] P_E  = 3'd3;
    localparam logic [2:0] P_W  = 3'd4;

    logic [W-1:0]  mem_r [5][FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_r [5];
    logic [AW-1:0] wr_ptr_r [5];
    logic [CW-1:0] count_r [5];
    logic [2:0]    rr_ptr_r [5];
    logic          ready_en_r;

    logic [W-1:0]  head_s [5];
    logic [W-1:0]  flit_s [5];
    logic [2:0]    route_s [5];
    logic [4:0]    req_s [5];
    logic [4:0]    can_load_s;
    logic [4:0]    gnt_any_s;
    logic [2:0]    gnt_idx_s [5];
    logic [W-1:0]  gnt_flit_s [5];
    logic [4:0]    push_s;
    logic [4:0]    pop_s;

    // Input acceptance: ready is held low until the first edge after reset releases
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            in_ready[i] = ready_en_r & (count_r[i] < CW'(FIFO_DEPTH));
        end
        push_s = in_valid & in_ready;
    end

    // Route computation on every FIFO head: X hops first, then Y, else local delivery
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            head_s[i] = mem_r[i][rd_ptr_r[i]];
            flit_s[i] = head_s[i];
            if (head_s[i][W-13 -: 4] != 4'd0) begin
                flit_s[i][W-13 -: 4] = head_s[i][W-13 -: 4] - 4'd1;
                route_s[i] = head_s[i][W-3] ? P_E : P_W;
            end else if (head_s[i][W-9 -: 4] != 4'd0) begin
                flit_s[i][W-9 -: 4] = head_s[i][W-9 -: 4] - 4'd1;
                route_s[i] = head_s[i][W-2] ? P_N : P_S;
            end else begin
                route_s[i] = P_PE;
            end
        end
    end

    // Per-output round-robin arbitration starting the scan at rr_ptr
    always_comb begin
        logic [3:0] idx;
        idx = 4'd0;
        pop_s = 5'd0;
        for (int o = 0; o < 5; o++) begin
            can_load_s[o] = !out_valid[o] | out_ready[o];
            gnt_any_s[o]  = 1'b0;
            gnt_idx_s[o]  = 3'd0;
            gnt_flit_s[o] = '0;
            for (int i = 0; i < 5; i++) begin
                req_s[o][i] = (count_r[i] != CW'(0)) && (route_s[i] == 3'(o));
            end
            for (int k = 0; k < 5; k++) begin
                idx = {1'b0, rr_ptr_r[o]} + 4'(k);
                if (idx >= 4'd5) begin
                    idx = idx - 4'd5;
                end else begin
                    idx = idx;
                end
                if (!gnt_any_s[o] && can_load_s[o] && req_s[o][idx[2:0]]) begin
                    gnt_any_s[o]  = 1'b1;
                    gnt_idx_s[o]  = idx[2:0];
                    gnt_flit_s[o] = flit_s[idx[2:0]];
                end else begin
                    gnt_any_s[o] = gnt_any_s[o];
                end
            end
            for (int i = 0; i < 5; i++) begin
                pop_s[i] = pop_s[i] | (gnt_any_s[o] && (gnt_idx_s[o] == 3'(i)));
            end
        end
    end

    // FIFO storage, pointers, output registers and arbiter pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_r <= 1'b0;
            out_valid  <= 5'd0;
            out_data   <= '0;
            for (int i = 0; i < 5; i++) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                count_r[i]  <= '0;
                rr_ptr_r[i] <= 3'd0;
            end
        end else begin
            ready_en_r <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= in_data[i*W +: W];
                    wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
                end
                count_r[i] <= count_r[i] + CW'(push_s[i]) - CW'(pop_s[i]);
            end
            for (int o = 0; o < 5; o++) begin
                if (gnt_any_s[o]) begin
                    out_data[o*W +: W] <= gnt_flit_s[o];
                    out_valid[o]       <= 1'b1;
                    rr_ptr_r[o]        <= (gnt_idx_s[o] == 3'd4) ? 3'd0 : gnt_idx_s[o] + 3'd1;
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end
endmodule
